// File: rtl/victim_wb_buffer_pkg.sv
// Shared cache constants: address field positions, line geometry and the
// write-back drain FSM encoding.
package victim_wb_buffer_pkg;

    localparam int ADR_WORD_OFFSET_BEGIN = 2;
    localparam int ADR_WORD_OFFSET_END   = 3;
    localparam int ADR_LINE_BEGIN        = 4;
    localparam int ADR_LINE_END          = 31;
    localparam int WORD_NUM              = 4;

    typedef enum logic {
        DR_IDLE = 1'b0,
        DR_SEND = 1'b1
    } dr_state_e;

endpackage

// File: rtl/victim_wb_buffer_entry.sv
// One buffered victim line: valid/mask bookkeeping, word write, lookup
// compare and two independent word-select read ports.
module wb_entry
    import victim_wb_buffer_pkg::*;
#(
    parameter int WORD_WIDTH        = 32,
    parameter int LINE_WIDTH        = 28,
    parameter int WORD_OFFSET_WIDTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic                         clr,
    input  logic [LINE_WIDTH-1:0]        wr_line,
    input  logic [WORD_OFFSET_WIDTH-1:0] wr_word,
    input  logic [WORD_WIDTH-1:0]        wr_dat,
    input  logic [LINE_WIDTH-1:0]        lkp_line,
    input  logic [WORD_OFFSET_WIDTH-1:0] lkp_word,
    input  logic [WORD_OFFSET_WIDTH-1:0] rd_word,
    output logic                         valid,
    output logic [(2**WORD_OFFSET_WIDTH)-1:0] mask,
    output logic [LINE_WIDTH-1:0]        line,
    output logic                         match,
    output logic [WORD_WIDTH-1:0]        lkp_dat,
    output logic [WORD_WIDTH-1:0]        rd_dat
);

    localparam int WORDS = 2 ** WORD_OFFSET_WIDTH;

    logic                  valid_r;
    logic [LINE_WIDTH-1:0] line_r;
    logic [WORDS-1:0]      mask_r;
    logic [WORD_WIDTH-1:0] data_r [WORDS];

    // Line storage: the first word into a free entry latches the line address.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            line_r  <= {LINE_WIDTH{1'b0}};
            mask_r  <= {WORDS{1'b0}};
            for (int i = 0; i < WORDS; i++) begin
                data_r[i] <= {WORD_WIDTH{1'b0}};
            end
        end else if (wr_en) begin
            if (!valid_r) begin
                valid_r <= 1'b1;
                line_r  <= wr_line;
            end
            mask_r[wr_word] <= 1'b1;
            data_r[wr_word] <= wr_dat;
        end else if (clr) begin
            valid_r <= 1'b0;
            mask_r  <= {WORDS{1'b0}};
        end
    end

    assign valid   = valid_r;
    assign mask    = mask_r;
    assign line    = line_r;
    assign match   = valid_r && (line_r == lkp_line) && mask_r[lkp_word];
    assign lkp_dat = data_r[lkp_word];
    assign rd_dat  = data_r[rd_word];

endmodule

// File: rtl/victim_wb_buffer.sv
// Victim write-back buffer: gathers evicted dirty lines word by word, drains
// them to memory in allocation order and forwards buffered words to refills.
module victim_wb_buffer
    import victim_wb_buffer_pkg::*;
#(
    parameter int WORD_WIDTH        = 32,
    parameter int ADR_WIDTH         = 32,
    parameter int WORD_OFFSET_WIDTH = 2,
    parameter int WORD_NUM          = 4,
    parameter int ENTRIES           = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         victim_valid_i,
    input  logic [ADR_WIDTH-1:0]         victim_adr_i,
    input  logic [WORD_WIDTH-1:0]        victim_dat_i,
    input  logic [WORD_OFFSET_WIDTH-1:0] victim_word_i,
    output logic                         victim_ready_o,
    output logic                         wb_req_o,
    output logic [ADR_WIDTH-1:0]         wb_adr_o,
    output logic [WORD_WIDTH-1:0]        wb_dat_o,
    input  logic                         wb_ack_i,
    input  logic [ADR_WIDTH-1:0]         lkp_adr_i,
    output logic                         lkp_hit_o,
    output logic [WORD_WIDTH-1:0]        lkp_dat_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int LINE_W = ADR_WIDTH - ADR_LINE_BEGIN;
    localparam int PTR_W  = $clog2(ENTRIES);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] ENTRIES_C = CNT_W'(ENTRIES);

    dr_state_e                  state_r;
    dr_state_e                  state_next_s;
    logic [WORD_OFFSET_WIDTH-1:0] cnt_r;
    logic [PTR_W-1:0]           fill_ptr_r;
    logic [PTR_W-1:0]           drain_ptr_r;
    logic [CNT_W-1:0]           count_r;

    logic [ENTRIES-1:0]         ent_valid_s;
    logic [ENTRIES-1:0]         ent_match_s;
    logic [ENTRIES-1:0]         ent_wr_s;
    logic [ENTRIES-1:0]         ent_clr_s;
    logic [WORD_NUM-1:0]        ent_mask_s    [ENTRIES];
    logic [LINE_W-1:0]          ent_line_s    [ENTRIES];
    logic [WORD_WIDTH-1:0]      ent_lkp_dat_s [ENTRIES];
    logic [WORD_WIDTH-1:0]      ent_rd_dat_s  [ENTRIES];

    logic                       ready_s;
    logic                       accept_s;
    logic [WORD_NUM-1:0]        word_onehot_s;
    logic                       fill_done_s;
    logic                       release_s;
    logic                       unused_s;

    assign unused_s = ^{victim_adr_i[ADR_LINE_BEGIN-1:0], lkp_adr_i[ADR_WORD_OFFSET_BEGIN-1:0]};

    assign ready_s       = (count_r < ENTRIES_C);
    assign accept_s      = victim_valid_i && ready_s;
    assign word_onehot_s = {{(WORD_NUM-1){1'b0}}, 1'b1} << victim_word_i;
    assign fill_done_s   = accept_s && ((ent_mask_s[fill_ptr_r] | word_onehot_s) == {WORD_NUM{1'b1}});
    assign release_s     = (state_r == DR_SEND) && wb_ack_i && (cnt_r == {WORD_OFFSET_WIDTH{1'b1}});

    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
        wb_entry #(
            .WORD_WIDTH        (WORD_WIDTH),
            .LINE_WIDTH        (LINE_W),
            .WORD_OFFSET_WIDTH (WORD_OFFSET_WIDTH)
        ) u_entry (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (ent_wr_s[g]),
            .clr      (ent_clr_s[g]),
            .wr_line  (victim_adr_i[ADR_WIDTH-1:ADR_LINE_BEGIN]),
            .wr_word  (victim_word_i),
            .wr_dat   (victim_dat_i),
            .lkp_line (lkp_adr_i[ADR_WIDTH-1:ADR_LINE_BEGIN]),
            .lkp_word (lkp_adr_i[ADR_WORD_OFFSET_END:ADR_WORD_OFFSET_BEGIN]),
            .rd_word  (cnt_r),
            .valid    (ent_valid_s[g]),
            .mask     (ent_mask_s[g]),
            .line     (ent_line_s[g]),
            .match    (ent_match_s[g]),
            .lkp_dat  (ent_lkp_dat_s[g]),
            .rd_dat   (ent_rd_dat_s[g])
        );
    end

    // Steer the victim write to the filling entry and the release to the draining one.
    always_comb begin
        ent_wr_s  = {ENTRIES{1'b0}};
        ent_clr_s = {ENTRIES{1'b0}};
        for (int i = 0; i < ENTRIES; i++) begin
            ent_wr_s[i]  = accept_s && (fill_ptr_r == PTR_W'(i));
            ent_clr_s[i] = release_s && (drain_ptr_r == PTR_W'(i));
        end
    end

    // Lookup walks oldest to newest from drain_ptr so the newest match overrides.
    always_comb begin
        logic [PTR_W-1:0] idx_s;
        idx_s     = {PTR_W{1'b0}};
        lkp_hit_o = 1'b0;
        lkp_dat_o = {WORD_WIDTH{1'b0}};
        for (int i = 0; i < ENTRIES; i++) begin
            idx_s     = drain_ptr_r + PTR_W'(i);
            lkp_dat_o = ent_match_s[idx_s] ? ent_lkp_dat_s[idx_s] : lkp_dat_o;
            lkp_hit_o = lkp_hit_o | ent_match_s[idx_s];
        end
    end

    // Queue pointers and completed-line count.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_ptr_r  <= {PTR_W{1'b0}};
            drain_ptr_r <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
        end else begin
            if (fill_done_s) begin
                fill_ptr_r <= fill_ptr_r + PTR_W'(1);
            end
            if (release_s) begin
                drain_ptr_r <= drain_ptr_r + PTR_W'(1);
            end
            case ({fill_done_s, release_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= DR_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Drain FSM next state: start on a completed line, stop after the last word's ack.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            DR_IDLE: state_next_s = (count_r != {CNT_W{1'b0}}) ? DR_SEND : DR_IDLE;
            DR_SEND: state_next_s = release_s ? DR_IDLE : DR_SEND;
            default: state_next_s = DR_IDLE;
        endcase
    end

    // Word counter within the draining line; wraps to zero on the final ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {WORD_OFFSET_WIDTH{1'b0}};
        end else if ((state_r == DR_SEND) && wb_ack_i) begin
            cnt_r <= cnt_r + WORD_OFFSET_WIDTH'(1);
        end else if (state_r == DR_IDLE) begin
            cnt_r <= {WORD_OFFSET_WIDTH{1'b0}};
        end
    end

    // Drain FSM outputs: the bus is quiet (all zero) outside DR_SEND.
    always_comb begin
        wb_req_o = 1'b0;
        wb_adr_o = {ADR_WIDTH{1'b0}};
        wb_dat_o = {WORD_WIDTH{1'b0}};
        case (state_r)
            DR_SEND: begin
                wb_req_o = 1'b1;
                wb_adr_o = {ent_line_s[drain_ptr_r], cnt_r, 2'b00};
                wb_dat_o = ent_rd_dat_s[drain_ptr_r];
            end
            default: begin
                wb_req_o = 1'b0;
            end
        endcase
    end

    assign victim_ready_o = ready_s;
    assign full_o         = (count_r == ENTRIES_C);
    assign empty_o        = (count_r == {CNT_W{1'b0}}) && !ent_valid_s[fill_ptr_r];

endmodule

// File: tb/tb_victim_wb_buffer.sv
// Scoreboard bench for victim_wb_buffer: completed lines push their expected
// memory writes, observed handshakes are popped and compared in order.
module tb_victim_wb_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        victim_valid_i;
    logic [31:0] victim_adr_i;
    logic [31:0] victim_dat_i;
    logic [1:0]  victim_word_i;
    logic        victim_ready_o;
    logic        wb_req_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic        wb_ack_i;
    logic [31:0] lkp_adr_i;
    logic        lkp_hit_o;
    logic [31:0] lkp_dat_o;
    logic        full_o;
    logic        empty_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q [$];
    logic [63:0] obs_q [$];

    always #5 clk = ~clk;

    victim_wb_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .victim_valid_i (victim_valid_i),
        .victim_adr_i   (victim_adr_i),
        .victim_dat_i   (victim_dat_i),
        .victim_word_i  (victim_word_i),
        .victim_ready_o (victim_ready_o),
        .wb_req_o       (wb_req_o),
        .wb_adr_o       (wb_adr_o),
        .wb_dat_o       (wb_dat_o),
        .wb_ack_i       (wb_ack_i),
        .lkp_adr_i      (lkp_adr_i),
        .lkp_hit_o      (lkp_hit_o),
        .lkp_dat_o      (lkp_dat_o),
        .full_o         (full_o),
        .empty_o        (empty_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_word(input logic [31:0] adr, input logic [1:0] w, input logic [31:0] d);
        victim_valid_i = 1'b1;
        victim_adr_i   = adr;
        victim_word_i  = w;
        victim_dat_i   = d;
        step();
        victim_valid_i = 1'b0;
    endtask

    task automatic push_line(input logic [31:0] line, input logic [31:0] d0, d1, d2, d3);
        logic [31:0] base;
        base = {line[31:4], 4'h0};
        exp_q.push_back({base,          d0});
        exp_q.push_back({base + 32'd4,  d1});
        exp_q.push_back({base + 32'd8,  d2});
        exp_q.push_back({base + 32'd12, d3});
    endtask

    // Ack every cycle; record each word transferred, up to n words or budget cycles.
    task automatic drain_words(input int n, input int budget);
        int got;
        got = 0;
        wb_ack_i = 1'b1;
        for (int c = 0; c < budget && got < n; c++) begin
            if (wb_req_o === 1'b1) begin
                obs_q.push_back({wb_adr_o, wb_dat_o});
                got++;
            end
            step();
        end
        wb_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; victim_valid_i = 1'b0; victim_adr_i = 32'h0; victim_dat_i = 32'h0;
        victim_word_i = 2'd0; wb_ack_i = 1'b0; lkp_adr_i = 32'h0;
        step(); step();
        rst = 1'b0;
        #1;
        n_cmp++; if (empty_o !== 1'b1)        begin n_err++; $display("FAIL reset_empty: got %b, expected 1", empty_o); end
        n_cmp++; if (victim_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b, expected 1", victim_ready_o); end
        n_cmp++; if (wb_req_o !== 1'b0)       begin n_err++; $display("FAIL reset_req: got %b, expected 0", wb_req_o); end
        n_cmp++; if (full_o !== 1'b0)         begin n_err++; $display("FAIL reset_full: got %b, expected 0", full_o); end
        n_cmp++; if ({wb_adr_o, wb_dat_o} !== 64'h0) begin n_err++; $display("FAIL reset_bus: got %h/%h, expected 0/0", wb_adr_o, wb_dat_o); end
        n_cmp++; if ({lkp_hit_o, lkp_dat_o} !== 33'h0) begin n_err++; $display("FAIL reset_lkp: got %b/%h, expected 0/0", lkp_hit_o, lkp_dat_o); end
    endtask

    task automatic test_fill_order();
        logic [63:0] e, o;
        put_word(32'h0000_1230, 2'd2, 32'hA2);
        put_word(32'h0000_1230, 2'd3, 32'hA3);
        put_word(32'h0000_1230, 2'd0, 32'hA0);
        put_word(32'h0000_1230, 2'd1, 32'hA1);
        push_line(32'h0000_1230, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        n_cmp++; if (wb_req_o !== 1'b0) begin n_err++; $display("FAIL fill_req_latency: req got %b at completion, expected 0", wb_req_o); end
        n_cmp++; if (empty_o !== 1'b0)  begin n_err++; $display("FAIL fill_not_empty: got %b, expected 0", empty_o); end
        step();
        n_cmp++; if (wb_req_o !== 1'b1) begin n_err++; $display("FAIL fill_req_rise: got %b, expected 1", wb_req_o); end
        drain_words(4, 4);
        n_cmp++; if (obs_q.size() !== 4) begin n_err++; $display("FAIL fill_b2b_count: got %0d writes in 4 cycles, expected 4", obs_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : {64{1'bx}};
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL fill_write: got %h/%h, expected %h/%h", o[63:32], o[31:0], e[63:32], e[31:0]); end
        end
        obs_q.delete();
        n_cmp++; if (empty_o !== 1'b1 || wb_req_o !== 1'b0) begin n_err++; $display("FAIL fill_after: empty/req got %b/%b, expected 1/0", empty_o, wb_req_o); end
    endtask

    task automatic test_full();
        logic [63:0] e, o;
        for (int w = 0; w < 4; w++) put_word(32'h0000_2000, w[1:0], 32'h2000_0000 + w);
        push_line(32'h0000_2000, 32'h2000_0000, 32'h2000_0001, 32'h2000_0002, 32'h2000_0003);
        for (int w = 3; w >= 0; w--) put_word(32'h0000_3000, w[1:0], 32'h3000_0000 + w);
        push_line(32'h0000_3000, 32'h3000_0000, 32'h3000_0001, 32'h3000_0002, 32'h3000_0003);
        n_cmp++; if (full_o !== 1'b1 || victim_ready_o !== 1'b0) begin n_err++; $display("FAIL full_flags: full/ready got %b/%b, expected 1/0", full_o, victim_ready_o); end
        put_word(32'h0000_6000, 2'd0, 32'hDEAD_BEEF);
        lkp_adr_i = 32'h0000_6000; #1;
        n_cmp++; if (lkp_hit_o !== 1'b0) begin n_err++; $display("FAIL full_drop_lkp: hit got %b, expected 0", lkp_hit_o); end
        n_cmp++; if (full_o !== 1'b1) begin n_err++; $display("FAIL full_drop_full: got %b, expected 1", full_o); end
        drain_words(4, 20);
        n_cmp++; if (victim_ready_o !== 1'b1 || full_o !== 1'b0) begin n_err++; $display("FAIL full_release: ready/full got %b/%b, expected 1/0", victim_ready_o, full_o); end
        drain_words(4, 20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : {64{1'bx}};
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL full_write: got %h/%h, expected %h/%h", o[63:32], o[31:0], e[63:32], e[31:0]); end
        end
        obs_q.delete();
    endtask

    task automatic test_lookup_partial();
        logic [63:0] e, o;
        put_word(32'h0000_1230, 2'd1, 32'hA1);
        lkp_adr_i = 32'h0000_1234; #1;
        n_cmp++; if (lkp_hit_o !== 1'b1 || lkp_dat_o !== 32'hA1) begin n_err++; $display("FAIL lkp_hit: got %b/%h, expected 1/000000a1", lkp_hit_o, lkp_dat_o); end
        lkp_adr_i = 32'h0000_1238; #1;
        n_cmp++; if (lkp_hit_o !== 1'b0 || lkp_dat_o !== 32'h0) begin n_err++; $display("FAIL lkp_miss: got %b/%h, expected 0/00000000", lkp_hit_o, lkp_dat_o); end
        put_word(32'h0000_1230, 2'd0, 32'hA0);
        put_word(32'h0000_1230, 2'd2, 32'hA2);
        put_word(32'h0000_1230, 2'd3, 32'hA3);
        push_line(32'h0000_1230, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        drain_words(4, 20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : {64{1'bx}};
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL lkp_write: got %h/%h, expected %h/%h", o[63:32], o[31:0], e[63:32], e[31:0]); end
        end
        obs_q.delete();
    endtask

    task automatic test_newer_wins();
        logic [63:0] e, o;
        for (int w = 0; w < 4; w++) put_word(32'h0000_4000, w[1:0], 32'h10 + w);
        push_line(32'h0000_4000, 32'h10, 32'h11, 32'h12, 32'h13);
        put_word(32'h0000_4000, 2'd0, 32'h20);
        lkp_adr_i = 32'h0000_4000; #1;
        n_cmp++; if (lkp_hit_o !== 1'b1 || lkp_dat_o !== 32'h20) begin n_err++; $display("FAIL newer_partial: got %b/%h, expected 1/00000020", lkp_hit_o, lkp_dat_o); end
        lkp_adr_i = 32'h0000_4004; #1;
        n_cmp++; if (lkp_hit_o !== 1'b1 || lkp_dat_o !== 32'h11) begin n_err++; $display("FAIL older_fallback: got %b/%h, expected 1/00000011", lkp_hit_o, lkp_dat_o); end
        for (int w = 1; w < 4; w++) put_word(32'h0000_4000, w[1:0], 32'h20 + w);
        push_line(32'h0000_4000, 32'h20, 32'h21, 32'h22, 32'h23);
        lkp_adr_i = 32'h0000_4008; #1;
        n_cmp++; if (lkp_hit_o !== 1'b1 || lkp_dat_o !== 32'h22) begin n_err++; $display("FAIL newer_full: got %b/%h, expected 1/00000022", lkp_hit_o, lkp_dat_o); end
        drain_words(8, 30);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : {64{1'bx}};
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL newer_write: got %h/%h, expected %h/%h", o[63:32], o[31:0], e[63:32], e[31:0]); end
        end
        obs_q.delete();
    endtask

    task automatic test_reset_mid_drain();
        logic [63:0] e, o;
        for (int w = 0; w < 4; w++) put_word(32'h0000_5000, w[1:0], 32'h50 + w);
        push_line(32'h0000_5000, 32'h50, 32'h51, 32'h52, 32'h53);
        drain_words(2, 10);
        for (int k = 0; k < 2; k++) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : {64{1'bx}};
            n_cmp++; if (o !== e) begin n_err++; $display("FAIL rstmid_write: got %h/%h, expected %h/%h", o[63:32], o[31:0], e[63:32], e[31:0]); end
        end
        exp_q.delete();
        obs_q.delete();
        rst = 1'b1;
        step();
        rst = 1'b0;
        lkp_adr_i = 32'h0000_5008; #1;
        n_cmp++; if (wb_req_o !== 1'b0) begin n_err++; $display("FAIL rstmid_req: got %b, expected 0", wb_req_o); end
        n_cmp++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL rstmid_empty: got %b, expected 1", empty_o); end
        n_cmp++; if (lkp_hit_o !== 1'b0) begin n_err++; $display("FAIL rstmid_lkp: got %b, expected 0", lkp_hit_o); end
        drain_words(4, 12);
        n_cmp++; if (obs_q.size() !== 0) begin n_err++; $display("FAIL rstmid_nowrite: got %0d writes, expected 0", obs_q.size()); end
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_fill_order();
        test_full();
        test_lookup_partial();
        test_newer_wins();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
